// File: rtl/dram_frame_write_ctrl_if.sv
// dram_frame_write_ctrl_if
// Groups the FIFO read side and the DRAM write-command side of the
// frame write controller.
//   fifo_empty/fifo_dout/fifo_last : FIFO read side (dout valid one cycle after fifo_rd_en)
//   fifo_rd_en                     : FIFO pop pulse
//   dram_write_en/addr/data        : DRAM write command; addr/data held while en is high
//   dram_write_busy                : write engine busy
// master: the controller. slave: the FIFO + write engine side.
interface dram_frame_write_ctrl_if #(
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned DRAM_DATA_WIDTH = 512
);
  logic                       fifo_empty;
  logic [DRAM_DATA_WIDTH-1:0] fifo_dout;
  logic                       fifo_last;
  logic                       fifo_rd_en;
  logic                       dram_write_en;
  logic [DRAM_ADDR_WIDTH-1:0] dram_write_addr;
  logic [DRAM_DATA_WIDTH-1:0] dram_write_data;
  logic                       dram_write_busy;

  modport master (
    input  fifo_empty, fifo_dout, fifo_last, dram_write_busy,
    output fifo_rd_en, dram_write_en, dram_write_addr, dram_write_data
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_last, dram_write_busy,
    input  fifo_rd_en, dram_write_en, dram_write_addr, dram_write_data
  );
endinterface

// File: rtl/dram_frame_write_ctrl.sv
// dram_frame_write_ctrl
// Pops words from the clock-crossing FIFO and issues one DRAM write per word
// into a ring of frame slots. Frames that find their slot occupied are
// drained from the FIFO and counted as dropped.
// Ports:
//   m_axi_aclk, reset            : clock, synchronous active-high reset
//   enable                       : allow new frames to start (sampled in IDLE only)
//   bus (master)                 : FIFO read side + DRAM write command
//   slot_release/_idx            : consumer hands a slot back
//   frame_done/_slot/_words      : pulse when a frame has been fully issued
//   slot_full                    : slot occupancy bitmap
//   overrun                      : sticky, a frame was cut at MAX_WORDS
//   drop_count                   : saturating count of dropped frames
module dram_frame_write_ctrl #(
  parameter int unsigned                DRAM_ADDR_WIDTH = 32,
  parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE  = 32'h80000000,
  parameter int unsigned                DRAM_DATA_WIDTH = 512,
  parameter int unsigned                FRAME_SLOTS     = 4,
  parameter logic [DRAM_ADDR_WIDTH-1:0] FRAME_STRIDE    = 32'h01000000,
  parameter int unsigned                MAX_WORDS       = 262144
) (
  input  logic                             m_axi_aclk,
  input  logic                             reset,
  input  logic                             enable,
  dram_frame_write_ctrl_if.master          bus,
  input  logic                             slot_release,
  input  logic [$clog2(FRAME_SLOTS)-1:0]   slot_release_idx,
  output logic                             frame_done,
  output logic [$clog2(FRAME_SLOTS)-1:0]   frame_done_slot,
  output logic [$clog2(MAX_WORDS):0]       frame_done_words,
  output logic [FRAME_SLOTS-1:0]           slot_full,
  output logic                             overrun,
  output logic [15:0]                      drop_count
);
  localparam int unsigned AW  = DRAM_ADDR_WIDTH;
  localparam int unsigned SW  = $clog2(FRAME_SLOTS);
  localparam int unsigned WW  = $clog2(MAX_WORDS) + 1;
  localparam int unsigned BPW = DRAM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_GUARD, S_WAIT, S_DROP_FETCH, S_DROP_LATCH
  } state_t;

  state_t                     state, state_nx;
  logic [SW-1:0]              cur_slot;
  logic [WW-1:0]              word_idx;
  logic                       last_q;
  logic [AW-1:0]              addr_q;
  logic [DRAM_DATA_WIDTH-1:0] data_q;
  logic [FRAME_SLOTS-1:0]     full_q;
  logic                       overrun_q;
  logic [15:0]                drop_q;

  logic rd_en, wr_en, done, frame_end, advance;
  logic [FRAME_SLOTS-1:0] set_mask, rel_mask;
  logic [AW-1:0] addr_calc;

  // A frame ends on its last word or when the slot capacity is reached.
  assign frame_end = last_q || (word_idx == WW'(MAX_WORDS - 1));
  assign addr_calc = DRAM_ADDR_BASE + AW'(cur_slot) * FRAME_STRIDE + AW'(word_idx) * AW'(BPW);

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    advance  = 1'b0;
    case (state)
      S_IDLE:
        if (enable && !bus.fifo_empty)
          state_nx = full_q[cur_slot] ? S_DROP_FETCH : S_FETCH;
      S_FETCH:
        if (!bus.fifo_empty) begin
          rd_en    = 1'b1;
          state_nx = S_LATCH;
        end
      S_LATCH: state_nx = S_ISSUE;
      S_ISSUE:
        if (!bus.dram_write_busy) begin
          wr_en    = 1'b1;
          state_nx = S_GUARD;
        end
      // The engine may raise busy up to one cycle after en, so busy is
      // not trusted here.
      S_GUARD: state_nx = S_WAIT;
      S_WAIT:
        if (!bus.dram_write_busy) begin
          if (frame_end) begin
            done     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            advance  = 1'b1;
            state_nx = S_FETCH;
          end
        end
      S_DROP_FETCH:
        if (!bus.fifo_empty) begin
          rd_en    = 1'b1;
          state_nx = S_DROP_LATCH;
        end
      S_DROP_LATCH: state_nx = bus.fifo_last ? S_IDLE : S_DROP_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // Set is OR-ed after the release clear, so a same-cycle set wins.
  assign set_mask = done ? (FRAME_SLOTS'(1) << cur_slot) : '0;
  assign rel_mask = slot_release ? (FRAME_SLOTS'(1) << slot_release_idx) : '0;

  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_slot  <= '0;
      word_idx  <= '0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      full_q    <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state  <= state_nx;
      full_q <= (full_q & ~rel_mask) | set_mask;
      if (state == S_LATCH) begin
        data_q <= bus.fifo_dout;
        last_q <= bus.fifo_last;
        addr_q <= addr_calc;
      end
      if (done) begin
        cur_slot <= cur_slot + SW'(1);
        word_idx <= '0;
        if (!last_q) overrun_q <= 1'b1;
      end
      if (advance) word_idx <= word_idx + WW'(1);
      if (state == S_DROP_LATCH && bus.fifo_last && drop_q != '1)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.fifo_rd_en      = rd_en;
  assign bus.dram_write_en   = wr_en;
  assign bus.dram_write_addr = addr_q;
  assign bus.dram_write_data = data_q;

  assign frame_done       = done;
  assign frame_done_slot  = done ? cur_slot : '0;
  assign frame_done_words = done ? (word_idx + WW'(1)) : '0;
  assign slot_full        = full_q;
  assign overrun          = overrun_q;
  assign drop_count       = drop_q;
endmodule
